// File: rtl/gift_128_pkg.sv
// GIFT-128 primitives shared by the core and its round datapath.
// Ports: none (package). Provides state enum, S-boxes, P128 index maps,
// round-constant table, key-schedule updates and the unroll-factor check.
package gift_128_pkg;

  localparam int ROUNDS = 40;

  typedef enum logic [2:0] {
    NOKEY,
    KEY_EXP,
    READY,
    RUN,
    DONE
  } gift_state_e;

  // Nibble x of each LUT sits at bits 4x+3:4x.
  localparam logic [63:0] SBOX_LUT     = 64'he805_7bd2_93f6_c4a1;
  localparam logic [63:0] SBOX_INV_LUT = 64'h5f93_a17e_b4c2_680d;

  // Constants of rounds 0..39, as produced by the 6-bit LFSR.
  localparam logic [5:0] RC_TABLE [0:ROUNDS-1] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  function automatic bit rpc_legal(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 5) ||
           (r == 8) || (r == 10) || (r == 20) || (r == 40);
  endfunction

  // Out-of-range indices only occur while the datapath is idle.
  function automatic logic [5:0] round_const(input logic [5:0] i);
    return (i < 6'(ROUNDS)) ? RC_TABLE[i] : 6'h00;
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_LUT[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV_LUT[{x, 2'b00} +: 4];
  endfunction

  // i = 16a + 4b + c  ->  32*((3b + c) mod 4) + 4a + c
  function automatic logic [6:0] p128_idx(input logic [6:0] i);
    logic [1:0] q;
    q = 2'(i[3:2] + i[3:2] + i[3:2] + i[1:0]);
    return {q, i[6:4], i[1:0]};
  endfunction

  // Inverse map: b = 3*(q - c) mod 4, since 3 is its own inverse mod 4.
  function automatic logic [6:0] p128_inv_idx(input logic [6:0] p);
    logic [1:0] d;
    logic [1:0] b;
    d = 2'(p[6:5] - p[1:0]);
    b = 2'(d + d + d);
    return {p[4:2], b, p[1:0]};
  endfunction

  function automatic logic [127:0] sub_cells(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      r[7'(4*j) +: 4] = inv ? sbox_inv(s[7'(4*j) +: 4]) : sbox(s[7'(4*j) +: 4]);
    end
    return r;
  endfunction

  function automatic logic [127:0] perm_fwd(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 128; j++) r[p128_idx(7'(j))] = s[7'(j)];
    return r;
  endfunction

  function automatic logic [127:0] perm_inv(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 128; j++) r[p128_inv_idx(7'(j))] = s[7'(j)];
    return r;
  endfunction

  // U = k5||k4 into bits 4m+2, V = k1||k0 into bits 4m+1, plus constant.
  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k,
                                                 input logic [5:0]   c);
    logic [127:0] r;
    r = s;
    for (int m = 0; m < 32; m++) begin
      r[7'(4*m+2)] = r[7'(4*m+2)] ^ k[7'(64+m)];
      r[7'(4*m+1)] = r[7'(4*m+1)] ^ k[7'(m)];
    end
    r[127] = ~r[127];
    r[23]  = r[23] ^ c[5];
    r[19]  = r[19] ^ c[4];
    r[15]  = r[15] ^ c[3];
    r[11]  = r[11] ^ c[2];
    r[7]   = r[7]  ^ c[1];
    r[3]   = r[3]  ^ c[0];
    return r;
  endfunction

  // k7..k0 <- (k1 >>> 2) || (k0 >>> 12) || k7..k2
  function automatic logic [127:0] key_fwd(input logic [127:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k);
    return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
  endfunction

endpackage

// File: rtl/gift_128_round.sv
// One combinational GIFT-128 round, encrypt (mode_i=0) or decrypt (mode_i=1).
// Latency: none. Backpressure: not applicable (pure logic).
// Ports: state_i/key_i/rc_i/mode_i in; state_o result, key_o key for the next chained round.
module gift_128_round
  import gift_128_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic [5:0]   rc_i,
  input  logic         mode_i,
  output logic [127:0] state_o,
  output logic [127:0] key_o
);

  logic [127:0] key_prev;

  always_comb begin
    key_prev = key_inv(key_i);
    state_o  = '0;
    key_o    = '0;
    if (!mode_i) begin
      state_o = add_round_key(perm_fwd(sub_cells(state_i, 1'b0)), key_i, rc_i);
      key_o   = key_fwd(key_i);
    end else begin
      // Decrypt walks the schedule backwards: the round key of round i
      // is recovered first, then the encrypt steps are undone in reverse.
      state_o = sub_cells(perm_inv(add_round_key(state_i, key_prev, rc_i)), 1'b1);
      key_o   = key_prev;
    end
  end

endmodule

// File: rtl/gift_128_core.sv
// GIFT-128 encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock (N = 40/ROUNDS_PER_CYCLE).
// Latency: key expansion N cycles, block N cycles accept-to-out_valid_o; registered outputs.
// Backpressure: result held in DONE until out_ready_i; key/data offers stall while busy.
// Ports: clk_i/reset, key_valid_i/key_i/key_ready_o/key_ok_o, data_valid_i/data_i/mode_i/
// data_ready_o, out_valid_o/out_ready_i/out_data_o/out_mode_o, busy_o.
module gift_128_core
  import gift_128_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic         key_valid_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  output logic         key_ok_o,
  input  logic         data_valid_i,
  input  logic [127:0] data_i,
  input  logic         mode_i,
  output logic         data_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         out_mode_o,
  output logic         busy_o
);

  if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
    $error("gift_128_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 5, 8, 10, 20 or 40");
  end

  localparam logic [5:0] STEP     = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_UP  = 6'(ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_DN  = 6'(ROUNDS_PER_CYCLE - 1);
  localparam logic [5:0] FIRST_DN = 6'(ROUNDS - 1);

  gift_state_e  fsm_q, fsm_d;
  logic [127:0] k0_q, k40_q, wkey_q, blk_q, out_data_q;
  logic [5:0]   rnd_q;
  logic         mode_q, key_ok_q, out_valid_q, out_mode_q, busy_q;

  logic         key_acc, data_acc, kexp_last, run_last;
  logic [127:0] kexp_next;
  logic [127:0] chain_s [ROUNDS_PER_CYCLE+1];
  logic [127:0] chain_k [ROUNDS_PER_CYCLE+1];

  assign key_ready_o  = (fsm_q == NOKEY) || (fsm_q == READY);
  assign data_ready_o = (fsm_q == READY) && !key_valid_i;
  assign key_acc      = key_valid_i && key_ready_o;
  assign data_acc     = data_valid_i && data_ready_o;

  assign kexp_last = (rnd_q == LAST_UP);
  assign run_last  = mode_q ? (rnd_q == LAST_DN) : (rnd_q == LAST_UP);

  assign key_ok_o    = key_ok_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_mode_o  = out_mode_q;
  assign busy_o      = busy_q;

  // Key expansion reuses k40_q as the accumulator, starting from K0.
  always_comb begin
    kexp_next = k40_q;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) kexp_next = key_fwd(kexp_next);
  end

  assign chain_s[0] = blk_q;
  assign chain_k[0] = wkey_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [5:0] rc_idx;
    assign rc_idx = mode_q ? (rnd_q - 6'(g)) : (rnd_q + 6'(g));
    gift_128_round u_round (
      .state_i (chain_s[g]),
      .key_i   (chain_k[g]),
      .rc_i    (round_const(rc_idx)),
      .mode_i  (mode_q),
      .state_o (chain_s[g+1]),
      .key_o   (chain_k[g+1])
    );
  end

  always_ff @(posedge clk_i) begin
    if (reset) fsm_q <= NOKEY;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      NOKEY:   if (key_acc) fsm_d = KEY_EXP;
      KEY_EXP: if (kexp_last) fsm_d = READY;
      READY: begin
        if (key_acc)       fsm_d = KEY_EXP;
        else if (data_acc) fsm_d = RUN;
      end
      RUN:     if (run_last) fsm_d = DONE;
      DONE:    if (out_ready_i) fsm_d = READY;
      default: fsm_d = NOKEY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      k0_q        <= '0;
      k40_q       <= '0;
      wkey_q      <= '0;
      blk_q       <= '0;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      key_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        NOKEY, READY: begin
          if (key_acc) begin
            k0_q     <= key_i;
            k40_q    <= key_i;
            rnd_q    <= '0;
            key_ok_q <= 1'b0;
          end else if (data_acc) begin
            blk_q  <= data_i;
            mode_q <= mode_i;
            wkey_q <= mode_i ? k40_q : k0_q;
            rnd_q  <= mode_i ? FIRST_DN : 6'd0;
          end
        end
        KEY_EXP: begin
          k40_q <= kexp_next;
          rnd_q <= rnd_q + STEP;
          if (kexp_last) key_ok_q <= 1'b1;
        end
        RUN: begin
          blk_q  <= chain_s[ROUNDS_PER_CYCLE];
          wkey_q <= chain_k[ROUNDS_PER_CYCLE];
          rnd_q  <= mode_q ? (rnd_q - STEP) : (rnd_q + STEP);
          if (run_last) begin
            out_data_q  <= chain_s[ROUNDS_PER_CYCLE];
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready_i) out_valid_q <= 1'b0;
        default: ;
      endcase
      busy_q <= (fsm_d == KEY_EXP) || (fsm_d == RUN) || (fsm_d == DONE);
    end
  end

endmodule

// File: tb/tb_gift_128_core.sv
// Directed bench for gift_128_core at ROUNDS_PER_CYCLE = 1, 4 and 40.
// Latency: expected N = 40, 10, 1 for key expansion and block processing.
// Backpressure: DONE hold, key/data priority and reset-in-RUN scenarios.
module tb_gift_128_core;

  localparam logic [127:0] KEY0 = 128'h0;
  localparam logic [127:0] PT0  = 128'h0;
  localparam logic [127:0] CT0  = 128'hcd0bd738388ad3f668b15a36ceb6ff92;
  localparam logic [127:0] KEY1 = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] PT1  = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] CT1  = 128'h8422241a6dbf5a9346af468409ee0152;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         key_valid  [3];
  logic [127:0] key        [3];
  logic         key_ready  [3];
  logic         key_ok     [3];
  logic         data_valid [3];
  logic [127:0] data       [3];
  logic         mode       [3];
  logic         data_ready [3];
  logic         out_valid  [3];
  logic         out_ready  [3];
  logic [127:0] out_data   [3];
  logic         out_mode   [3];
  logic         busy       [3];

  int checks = 0;
  int fails  = 0;

  gift_128_core #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (
    .clk_i(clk), .reset(reset),
    .key_valid_i(key_valid[0]), .key_i(key[0]), .key_ready_o(key_ready[0]), .key_ok_o(key_ok[0]),
    .data_valid_i(data_valid[0]), .data_i(data[0]), .mode_i(mode[0]), .data_ready_o(data_ready[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .out_mode_o(out_mode[0]), .busy_o(busy[0])
  );

  gift_128_core #(.ROUNDS_PER_CYCLE(4)) u_dut_r4 (
    .clk_i(clk), .reset(reset),
    .key_valid_i(key_valid[1]), .key_i(key[1]), .key_ready_o(key_ready[1]), .key_ok_o(key_ok[1]),
    .data_valid_i(data_valid[1]), .data_i(data[1]), .mode_i(mode[1]), .data_ready_o(data_ready[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .out_mode_o(out_mode[1]), .busy_o(busy[1])
  );

  gift_128_core #(.ROUNDS_PER_CYCLE(40)) u_dut_r40 (
    .clk_i(clk), .reset(reset),
    .key_valid_i(key_valid[2]), .key_i(key[2]), .key_ready_o(key_ready[2]), .key_ok_o(key_ok[2]),
    .data_valid_i(data_valid[2]), .data_i(data[2]), .mode_i(mode[2]), .data_ready_o(data_ready[2]),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_data_o(out_data[2]),
    .out_mode_o(out_mode[2]), .busy_o(busy[2])
  );

  function automatic int n_of(input int idx);
    case (idx)
      0:       return 40;
      1:       return 10;
      default: return 1;
    endcase
  endfunction

  // Offers a key, returns busy right after acceptance and cycles until key_ok.
  task automatic load_key(input int idx, input logic [127:0] k,
                          output int lat, output logic busy_after);
    int w;
    w = 0;
    @(negedge clk);
    while (key_ready[idx] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    key[idx] = k;
    key_valid[idx] = 1'b1;
    @(negedge clk);
    key_valid[idx] = 1'b0;
    busy_after = busy[idx];
    lat = 0;
    while (key_ok[idx] !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
  endtask

  // Runs one block with out_ready held high; lat counts edges from accept to out_valid.
  task automatic run_block(input int idx, input logic [127:0] d, input logic m,
                           output logic [127:0] res, output logic rm,
                           output int lat, output logic fell);
    int w;
    w = 0;
    @(negedge clk);
    while (data_ready[idx] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    data[idx] = d;
    mode[idx] = m;
    out_ready[idx] = 1'b1;
    data_valid[idx] = 1'b1;
    @(negedge clk);
    data_valid[idx] = 1'b0;
    lat = 0;
    while (out_valid[idx] !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    res = out_data[idx];
    rm  = out_mode[idx];
    @(negedge clk);
    fell = ~out_valid[idx];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_valid[i] = 1'b0; key[i] = '0; data_valid[i] = 1'b0; data[i] = '0;
      mode[i] = 1'b0; out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({key_ready[i], data_ready[i], key_ok[i], out_valid[i], busy[i], out_mode[i]} !== 6'b100000) begin
        fails++;
        $display("FAIL reset_flags[%0d]: got %b, want 100000", i,
                 {key_ready[i], data_ready[i], key_ok[i], out_valid[i], busy[i], out_mode[i]});
      end
      checks++;
      if (out_data[i] !== 128'h0) begin
        fails++; $display("FAIL reset_out_data[%0d]: got %h, want 0", i, out_data[i]);
      end
      data_valid[i] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({data_ready[i], busy[i]} !== 2'b00) begin
        fails++; $display("FAIL nokey_data_blocked[%0d]: got %b, want 00", i, {data_ready[i], busy[i]});
      end
      data_valid[i] = 1'b0;
    end
  endtask

  task automatic test_cipher(input int idx);
    int n, lat;
    logic b, rm, fell;
    logic [127:0] res;
    n = n_of(idx);

    load_key(idx, KEY0, lat, b);
    checks++; if (b !== 1'b1) begin fails++; $display("FAIL busy_after_key[%0d]: got %b, want 1", idx, b); end
    checks++; if (lat !== n) begin fails++; $display("FAIL key_ok_latency[%0d]: got %0d, want %0d", idx, lat, n); end

    run_block(idx, PT0, 1'b0, res, rm, lat, fell);
    checks++; if (res !== CT0) begin fails++; $display("FAIL enc0[%0d]: got %h, want %h", idx, res, CT0); end
    checks++; if (rm !== 1'b0) begin fails++; $display("FAIL enc0_mode[%0d]: got %b, want 0", idx, rm); end
    checks++; if (lat !== n) begin fails++; $display("FAIL enc0_latency[%0d]: got %0d, want %0d", idx, lat, n); end
    checks++; if (fell !== 1'b1) begin fails++; $display("FAIL enc0_valid_fall[%0d]: got %b, want 1", idx, fell); end

    run_block(idx, CT0, 1'b1, res, rm, lat, fell);
    checks++; if (res !== PT0) begin fails++; $display("FAIL dec0[%0d]: got %h, want %h", idx, res, PT0); end
    checks++; if (rm !== 1'b1) begin fails++; $display("FAIL dec0_mode[%0d]: got %b, want 1", idx, rm); end
    checks++; if (lat !== n) begin fails++; $display("FAIL dec0_latency[%0d]: got %0d, want %0d", idx, lat, n); end

    load_key(idx, KEY1, lat, b);
    checks++; if (lat !== n) begin fails++; $display("FAIL key1_ok_latency[%0d]: got %0d, want %0d", idx, lat, n); end

    run_block(idx, PT1, 1'b0, res, rm, lat, fell);
    checks++; if (res !== CT1) begin fails++; $display("FAIL enc1[%0d]: got %h, want %h", idx, res, CT1); end

    run_block(idx, CT1, 1'b1, res, rm, lat, fell);
    checks++; if (res !== PT1) begin fails++; $display("FAIL dec1[%0d]: got %h, want %h", idx, res, PT1); end
    checks++; if (rm !== 1'b1) begin fails++; $display("FAIL dec1_mode[%0d]: got %b, want 1", idx, rm); end
  endtask

  task automatic test_backpressure();
    int w;
    w = 0;
    @(negedge clk);
    while (data_ready[0] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    data[0] = PT1; mode[0] = 1'b0; out_ready[0] = 1'b0; data_valid[0] = 1'b1;
    @(negedge clk);
    data_valid[0] = 1'b0;
    w = 0;
    while (out_valid[0] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    repeat (20) begin
      checks++;
      if ({out_valid[0], data_ready[0], key_ready[0]} !== 3'b100 || out_data[0] !== CT1) begin
        fails++;
        $display("FAIL done_hold: flags %b data %h, want 100 data %h",
                 {out_valid[0], data_ready[0], key_ready[0]}, out_data[0], CT1);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid[0], data_ready[0], key_ready[0], busy[0]} !== 4'b0110) begin
      fails++;
      $display("FAIL done_release: got %b, want 0110", {out_valid[0], data_ready[0], key_ready[0], busy[0]});
    end
  endtask

  task automatic test_key_priority();
    int w, lat;
    w = 0;
    @(negedge clk);
    while (data_ready[1] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    key[1] = KEY0; key_valid[1] = 1'b1;
    data[1] = PT0; mode[1] = 1'b0; data_valid[1] = 1'b1; out_ready[1] = 1'b1;
    #1;
    checks++;
    if ({key_ready[1], data_ready[1]} !== 2'b10) begin
      fails++; $display("FAIL prio_ready: got %b, want 10", {key_ready[1], data_ready[1]});
    end
    @(negedge clk);
    key_valid[1] = 1'b0;
    checks++;
    if ({key_ok[1], busy[1], out_valid[1]} !== 3'b010) begin
      fails++; $display("FAIL prio_key_taken: got %b, want 010", {key_ok[1], busy[1], out_valid[1]});
    end
    lat = 0;
    while (key_ok[1] !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (lat !== 10) begin fails++; $display("FAIL prio_key_latency: got %0d, want 10", lat); end
    checks++; if (data_ready[1] !== 1'b1) begin fails++; $display("FAIL prio_data_ready: got %b, want 1", data_ready[1]); end
    @(negedge clk);
    data_valid[1] = 1'b0;
    lat = 0;
    while (out_valid[1] !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (lat !== 10) begin fails++; $display("FAIL prio_block_latency: got %0d, want 10", lat); end
    checks++; if (out_data[1] !== CT0) begin fails++; $display("FAIL prio_block_data: got %h, want %h", out_data[1], CT0); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_run();
    int w, pulses, dr, lat;
    logic b, rm, fell;
    logic [127:0] res;
    w = 0;
    @(negedge clk);
    while (data_ready[0] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    data[0] = PT1; mode[0] = 1'b0; out_ready[0] = 1'b1; data_valid[0] = 1'b1;
    @(negedge clk);
    data_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy[0], out_valid[0]} !== 2'b10) begin
      fails++; $display("FAIL run_before_reset: got %b, want 10", {busy[0], out_valid[0]});
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({key_ready[i], data_ready[i], key_ok[i], out_valid[i], busy[i], out_mode[i]} !== 6'b100000 ||
          out_data[i] !== 128'h0) begin
        fails++;
        $display("FAIL reset_in_run[%0d]: flags %b data %h, want 100000 data 0", i,
                 {key_ready[i], data_ready[i], key_ok[i], out_valid[i], busy[i], out_mode[i]}, out_data[i]);
      end
    end
    reset = 1'b0;
    data[0] = PT0; data_valid[0] = 1'b1;
    pulses = 0; dr = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) pulses++;
      if (data_ready[0] === 1'b1) dr++;
    end
    data_valid[0] = 1'b0;
    checks++; if (pulses !== 0) begin fails++; $display("FAIL reset_no_output: got %0d pulses, want 0", pulses); end
    checks++; if (dr !== 0) begin fails++; $display("FAIL reset_no_data_ready: got %0d cycles, want 0", dr); end

    load_key(0, KEY0, lat, b);
    run_block(0, PT0, 1'b0, res, rm, lat, fell);
    checks++; if (res !== CT0) begin fails++; $display("FAIL post_reset_enc: got %h, want %h", res, CT0); end
    checks++; if (lat !== 40) begin fails++; $display("FAIL post_reset_latency: got %0d, want 40", lat); end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 3; i++) test_cipher(i);
    test_backpressure();
    test_key_priority();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/gift_128_core.md
# gift_128_core

Unified, parametrised GIFT-128 block-cipher engine. One instance performs both encryption and decryption and unrolls a configurable number of rounds per clock. It succeeds the separate fixed one-round-per-cycle encrypt controller and decrypt block. Holds one loaded key, pre-expands it once to the final round key, then processes 128-bit blocks through valid/ready handshakes on input and output. It sits between the key/data front end and the ciphertext/plaintext consumer.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds evaluated per clock. Legal values are 1, 2, 4, 5, 8, 10, 20, 40; any other value fails elaboration. Let N = 40/ROUNDS_PER_CYCLE.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid_i`  in  1  key offer.
- `key_i`  in  128  key, k7..k0 with k0 in bits 15:0.
- `key_ready_o`  out  1  key accepted when valid&ready.
- `key_ok_o`  out  1  expanded key available.
- `data_valid_i`  in  1  block offer.
- `data_i`  in  128  plaintext (enc) or ciphertext (dec).
- `mode_i`  in  1  0 = encrypt, 1 = decrypt; sampled with data.
- `data_ready_o`  out  1  block accepted when valid&ready.
- `out_valid_o`  out  1  result available.
- `out_ready_i`  in  1  consumer accepts result.
- `out_data_o`  out  128  result.
- `out_mode_o`  out  1  mode of the current result.
- `busy_o`  out  1  high in KEY_EXP, RUN, DONE.

## Operation
- FSM states: NOKEY, KEY_EXP, READY, RUN, DONE. Reset puts the FSM in NOKEY.
- `key_ready_o` = state ∈ {NOKEY, READY}.
- `data_ready_o` = (state == READY) && !key_valid_i. A key offer takes priority over a data offer.
- Key accept: store K0 = key_i, clear `key_ok_o`, go to KEY_EXP. KEY_EXP applies the forward key update ROUNDS_PER_CYCLE times per cycle for N cycles, storing K40. It then goes to READY and sets `key_ok_o`.
- Key update (forward): k7..k0 ← (k1>>>2) || (k0>>>12) || k7..k2.
- Key update (inverse) is the exact inverse of the forward update.
- Encrypt round i (0..39), applied to the state:
  - S-box on all 32 nibbles.
  - P128: bit j moves to position given by the spec permutation.
  - XOR U = k5||k4 into bits 4m+2 and V = k1||k0 into bits 4m+1, for m = 0..31.
  - XOR 1 into bit 127.
  - XOR c5..c0 into bits 23, 19, 15, 11, 7, 3.
  - Forward-update the round-key register.
- Decrypt round i (39..0):
  - Inverse-update the key register.
  - XOR the key and constant of round i.
  - Inverse P128.
  - Inverse S-box.
- Round constants: 6-bit LFSR starting at 0, update (c5..c0) ← (c4, c3, c2, c1, c0, c5^c4^1). Stored as a 40-entry table; the first entry is 0x01.
- Data accept: latch data_i and mode_i. Load the working key register from K0 (enc) or K40 (dec). Load the round counter with 0 (enc) or 39 (dec). Go to RUN.
- RUN: ROUNDS_PER_CYCLE chained rounds per cycle. The counter steps by ±ROUNDS_PER_CYCLE. After N cycles the FSM goes to DONE.
- DONE: `out_valid_o` = 1; `out_data_o` and `out_mode_o` are held stable. On out_valid&out_ready the FSM returns to READY.
- The stored K0 and K40 persist across blocks. Keys offered in RUN or DONE stall until READY.
- Reset in any state:
  - FSM → NOKEY.
  - `key_ok_o`, `out_valid_o`, `busy_o` = 0.
  - `out_data_o` = 0, `out_mode_o` = 0.
  - Key registers cleared.
  - In-flight block discarded, no output produced.

## Timing
- Key accepted at edge T: `busy_o` goes high after T. `key_ok_o` goes high at edge T+N. `data_ready_o` can be high from T+N.
- Block accepted at edge T: `out_valid_o` rises at edge T+N. With `out_ready_i` held high it falls at T+N+1.
- Best-case block period is N+2 cycles.
- Outputs are registered. Ready signals are combinational from state, plus `key_valid_i` in the case of `data_ready_o`.
- Backpressure: DONE persists indefinitely. No result is ever dropped or overwritten.

## Structure
- Package `gift_128_pkg`:
  - S-box and inverse S-box.
  - P128 and inverse index functions.
  - 40×6 round-constant table.
  - Forward and inverse key-update functions.
  - Rounds constant (40) and the legal-ROUNDS_PER_CYCLE check function.
- Sub-module `gift_128_round`: combinational, one round in either direction. Inputs: state, key, constant, mode. Outputs: state and the next key. Chained ROUNDS_PER_CYCLE times with generate.
- Top level holds the FSM, round counter, K0/K40/working-key registers and output registers.

## Test plan
- ROUNDS_PER_CYCLE=1, key 0, encrypt pt 0 → `out_data_o` = cd0bd738388ad3f668b15a36ceb6ff92, `out_valid_o` exactly 40 cycles after accept, `out_mode_o` = 0.
- Key fedcba9876543210fedcba9876543210, encrypt pt fedcba9876543210fedcba9876543210 → 8422241a6dbf5a9346af468409ee0152.
- Decrypt each ciphertext above with its key → the original plaintext, `out_mode_o` = 1. Repeat for ROUNDS_PER_CYCLE = 4 and 40, checking latencies of 10 and 1 cycles.
- Hold `out_ready_i` low for 20 cycles in DONE → `out_data_o` stable, `data_ready_o` = 0, `key_ready_o` = 0. Release → handshake completes in one cycle, then READY.
- Assert `key_valid_i` and `data_valid_i` together in READY → key accepted, block not accepted, `key_ok_o` drops and returns after N cycles. The block is accepted afterwards and encrypted under the new key.
- Assert `reset` 5 cycles into RUN → next cycle all outputs are 0 and the FSM is in NOKEY. `data_ready_o` stays 0 until a key is loaded, and no `out_valid_o` pulse occurs.
